// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: default geometry, reset PC and the
// 8-bit instruction encoding (opcode / register fields) that decode and the
// ALU also use.
package fetch_unit_pkg;

  // Default geometry of the fetch stage
  localparam int IW_DEF    = 8;
  localparam int AW_DEF    = 8;
  localparam int DEPTH_DEF = 3;

  // PC loaded on reset
  localparam int unsigned RESET_PC_DEF = 0;

  // Instruction word layout: {op[3:0], rd[1:0], rs[1:0]}
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_BEQ = 4'hA;

  localparam logic [1:0] R_0 = 2'd0;
  localparam logic [1:0] R_1 = 2'd1;
  localparam logic [1:0] R_2 = 2'd2;
  localparam logic [1:0] R_3 = 2'd3;

  // Build an instruction word from its fields
  function automatic logic [7:0] mk_instr(input logic [3:0] op,
                                          input logic [1:0] rd,
                                          input logic [1:0] rs);
    return {op, rd, rs};
  endfunction

  // Canonical no-operation
  localparam logic [7:0] NOP_INSTR = {OP_NOP, R_0, R_0};

endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// Small synchronous FIFO with flush and occupancy output. Head is read
// straight from storage (no write-through bypass), so a pushed word becomes
// visible one cycle after the push.
module sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 3,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Flush wins over both push and pop; pop on empty and push on full are ignored
  always_comb begin
    do_pop  = pop & (count != '0) & ~flush;
    do_push = push & ~flush & ((count != CW'(DEPTH)) | do_pop);
  end

  assign head = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; cleared on reset so the head reads as zero out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Issues reads to a 1-cycle-latency instruction
// memory, parks returned words with their PC in a small FIFO and hands
// {instr, pc} to decode over valid/ready. A redirect reloads the PC and
// throws away everything buffered or in flight.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          IW       = IW_DEF,
  parameter int          AW       = AW_DEF,
  parameter int          DEPTH    = DEPTH_DEF,
  parameter int unsigned RESET_PC = RESET_PC_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_rd_en,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_rdata,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic [IW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0]    pc;
  logic             inflight;
  logic [AW-1:0]    inflight_pc;
  logic             drop;

  logic [CW-1:0]    fifo_count;
  logic [IW+AW-1:0] fifo_head;
  logic [CW:0]      occ;
  logic             req, push, pop;

  // Occupancy counts the word still coming back from memory, so a request is
  // only made when a FIFO slot is guaranteed for its response.
  always_comb begin
    occ  = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
    req  = rst_n & ~redirect_valid & (occ < (CW + 1)'(DEPTH));
    push = inflight & ~drop & ~redirect_valid;
    pop  = instr_valid & instr_ready;
  end

  assign imem_rd_en  = req;
  assign imem_addr   = pc;
  assign instr_valid = (fifo_count != '0);
  assign instr       = instr_valid ? fifo_head[IW+AW-1:AW] : '0;
  assign instr_pc    = instr_valid ? fifo_head[AW-1:0]     : '0;

  // PC and in-flight tracking; redirect overrides any request this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= AW'(RESET_PC);
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      pc          <= redirect_pc;
      inflight    <= 1'b0;
    end else if (req) begin
      pc          <= pc + 1'b1;
      inflight    <= 1'b1;
      inflight_pc <= pc;
    end else begin
      inflight    <= 1'b0;
    end
  end

  // Stale-response mask. Redirect already suppresses the push of the word it
  // overlaps, so nothing here sets it; it only ever clears on redirect and
  // gates the push, leaving a single hook for any later flush source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              drop <= 1'b0;
    else if (redirect_valid) drop <= 1'b0;
  end

  sync_fifo #(
    .W     (IW + AW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({imem_rdata, inflight_pc}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

endmodule
